// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of a single SDRAM controller with an m_ready blanking window.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module sdram_arbiter #(
    parameter int BLANK_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [31:0] s0_addr,
    input  logic [31:0] s0_wdata,
    input  logic [3:0]  s0_wstrb,
    output logic [31:0] s0_rdata,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [31:0] s1_addr,
    input  logic [31:0] s1_wdata,
    input  logic [3:0]  s1_wstrb,
    output logic [31:0] s1_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int CW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_q, grant_d;
    logic          m_valid_q, m_valid_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic [3:0]    m_wstrb_q, m_wstrb_d;
    logic          s0_ready_q, s0_ready_d;
    logic          s1_ready_q, s1_ready_d;
    logic [31:0]   s0_rdata_q, s0_rdata_d;
    logic [31:0]   s1_rdata_q, s1_rdata_d;
    logic          pick;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign pick = ~s0_valid;
`else
    logic last_q, last_d;
    // On a tie the port that did not win last time is served; otherwise whoever asks.
    assign pick = (s0_valid && s1_valid) ? ~last_q : ~s0_valid;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        m_valid_d  = m_valid_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_wstrb_d  = m_wstrb_q;
        s0_ready_d = s0_ready_q;
        s1_ready_d = s1_ready_q;
        s0_rdata_d = s0_rdata_q;
        s1_rdata_d = s1_rdata_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    grant_d   = pick;
                    m_addr_d  = pick ? s1_addr  : s0_addr;
                    m_wdata_d = pick ? s1_wdata : s0_wdata;
                    m_wstrb_d = pick ? s1_wstrb : s0_wstrb;
                    m_valid_d = 1'b1;
                    cnt_d     = CW'(BLANK_CYCLES);
                    state_d   = ISSUE;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                    last_d    = pick;
`endif
                end
            end
            // The counter is checked before decrementing, so ISSUE spans BLANK_CYCLES+1 cycles.
            ISSUE: begin
                if (cnt_q == '0) begin
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT: begin
                if (m_ready) begin
                    if (grant_q) begin
                        s1_rdata_d = m_rdata;
                        s1_ready_d = 1'b1;
                    end else begin
                        s0_rdata_d = m_rdata;
                        s0_ready_d = 1'b1;
                    end
                    m_valid_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                s0_ready_d = 1'b0;
                s1_ready_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= 1'b0;
            m_valid_q  <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_wstrb_q  <= '0;
            s0_ready_q <= 1'b0;
            s1_ready_q <= 1'b0;
            s0_rdata_q <= '0;
            s1_rdata_q <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            m_valid_q  <= m_valid_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_wstrb_q  <= m_wstrb_d;
            s0_ready_q <= s0_ready_d;
            s1_ready_q <= s1_ready_d;
            s0_rdata_q <= s0_rdata_d;
            s1_rdata_q <= s1_rdata_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            last_q     <= last_d;
`endif
        end
    end

    assign m_valid  = m_valid_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_wstrb  = m_wstrb_q;
    assign s0_ready = s0_ready_q;
    assign s1_ready = s1_ready_q;
    assign s0_rdata = s0_rdata_q;
    assign s1_rdata = s1_rdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_sdram_arbiter;

    localparam int BLANK = 3;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid [2];
    logic [31:0] reqAddr  [2];
    logic [31:0] reqWdata [2];
    logic [3:0]  reqWstrb [2];
    logic        mReady;
    logic [31:0] mRdata;

    logic        s0Valid, s1Valid;
    logic        s0Ready, s1Ready;
    logic [31:0] s0Rdata, s1Rdata;
    logic        mValid;
    logic [31:0] mAddr, mWdata;
    logic [3:0]  mWstrb;

    assign s0Valid = reqValid[0];
    assign s1Valid = reqValid[1];

    always #5 clk = ~clk;

    sdram_arbiter #(.BLANK_CYCLES(BLANK)) dut (
        .clk      (clk),
        .rst_n    (rstN),
        .s0_valid (s0Valid),
        .s0_ready (s0Ready),
        .s0_addr  (reqAddr[0]),
        .s0_wdata (reqWdata[0]),
        .s0_wstrb (reqWstrb[0]),
        .s0_rdata (s0Rdata),
        .s1_valid (s1Valid),
        .s1_ready (s1Ready),
        .s1_addr  (reqAddr[1]),
        .s1_wdata (reqWdata[1]),
        .s1_wstrb (reqWstrb[1]),
        .s1_rdata (s1Rdata),
        .m_valid  (mValid),
        .m_ready  (mReady),
        .m_addr   (mAddr),
        .m_wdata  (mWdata),
        .m_wstrb  (mWstrb),
        .m_rdata  (mRdata)
    );

    // Scoreboard counters
    int errCount   = 0;
    int checkCount = 0;

    // Reference model: one outstanding transaction, its age in m_valid cycles,
    // the port due a completion pulse, and the expected registered outputs.
    bit          mBusy;
    int          mAge;
    int          pulsePort;
    int          gPort;
    int          lastGrant;
    logic [31:0] eAddr, eWdata;
    logic [3:0]  eWstrb;
    logic [31:0] eRdata [2];
    int          grantLog [$];

    // Requester / controller behaviour knobs
    bit pend    [2];
    bit keepReq [2];
    bit randReq;
    bit randResp;
    int pulseCnt [2];

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance the model across one clock edge using the inputs present at that edge
    task automatic modelStep();
        int w;
        if (!rstN) begin
            mBusy     = 1'b0;
            pulsePort = -1;
            eAddr     = '0;
            eWdata    = '0;
            eWstrb    = '0;
            eRdata[0] = '0;
            eRdata[1] = '0;
            lastGrant = 1;
        end else if (pulsePort >= 0) begin
            pulsePort = -1;
        end else if (!mBusy) begin
            if (reqValid[0] || reqValid[1]) begin
                if (reqValid[0] && reqValid[1]) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                    w = 0;
`else
                    w = 1 - lastGrant;
`endif
                end else begin
                    w = reqValid[0] ? 0 : 1;
                end
                gPort     = w;
                lastGrant = w;
                eAddr     = reqAddr[w];
                eWdata    = reqWdata[w];
                eWstrb    = reqWstrb[w];
                mBusy     = 1'b1;
                mAge      = 0;
                grantLog.push_back(w);
            end
        end else if (mAge >= BLANK + 1 && mReady) begin
            eRdata[gPort] = mRdata;
            pulsePort     = gPort;
            mBusy         = 1'b0;
        end else begin
            mAge++;
        end
    endtask

    task automatic newReq(input int p);
        reqAddr[p]  = $urandom();
        reqWdata[p] = $urandom();
        reqWstrb[p] = 4'($urandom_range(0, 15));
        reqValid[p] = 1'b1;
        pend[p]     = 1'b1;
    endtask

    task automatic startReq(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        reqAddr[p]  = a;
        reqWdata[p] = d;
        reqWstrb[p] = s;
        reqValid[p] = 1'b1;
        pend[p]     = 1'b1;
    endtask

    // One clock: sample #1 after the edge, compare to the model, then react as requesters/controller
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        modelStep();
        checkOutput("m_valid",  32'(mValid),  32'(mBusy));
        checkOutput("s0_ready", 32'(s0Ready), 32'(pulsePort == 0));
        checkOutput("s1_ready", 32'(s1Ready), 32'(pulsePort == 1));
        checkOutput("m_addr",   mAddr,        eAddr);
        checkOutput("m_wdata",  mWdata,       eWdata);
        checkOutput("m_wstrb",  32'(mWstrb),  32'(eWstrb));
        checkOutput("s0_rdata", s0Rdata,      eRdata[0]);
        checkOutput("s1_rdata", s1Rdata,      eRdata[1]);
        pulseCnt[0] += int'(s0Ready);
        pulseCnt[1] += int'(s1Ready);

        for (int p = 0; p < 2; p++) begin
            if (!rstN && pend[p] && !reqValid[p]) pend[p] = 1'b0;
            if (pulsePort == p) begin
                pend[p] = 1'b0;
                if (keepReq[p]) newReq(p);
                else reqValid[p] = 1'b0;
            end else if (randReq) begin
                if (!pend[p] && $urandom_range(0, 3) == 0) newReq(p);
                else if (pend[p] && reqValid[p] && mBusy && gPort == p && $urandom_range(0, 7) == 0)
                    reqValid[p] = 1'b0;
            end
        end
        if (randResp) begin
            mReady = ($urandom_range(0, 2) == 0);
            mRdata = $urandom();
        end
    endtask

    // Bounded drain: run until no request is outstanding anywhere
    task automatic waitIdle(input int budget, input string tag);
        int n;
        bit done;
        n = 0;
        while ((pend[0] || pend[1] || mBusy || pulsePort >= 0) && n < budget) begin
            applyStimulus();
            n++;
        end
        done = !(pend[0] || pend[1] || mBusy || pulsePort >= 0);
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        int expPort;
        int gotPort;

        rstN      = 1'b0;
        mReady    = 1'b0;
        mRdata    = '0;
        mBusy     = 1'b0;
        mAge      = 0;
        pulsePort = -1;
        gPort     = 0;
        lastGrant = 1;
        randReq   = 1'b0;
        randResp  = 1'b0;
        for (int p = 0; p < 2; p++) begin
            reqValid[p] = 1'b0;
            reqAddr[p]  = '0;
            reqWdata[p] = '0;
            reqWstrb[p] = '0;
            pend[p]     = 1'b0;
            keepReq[p]  = 1'b0;
            pulseCnt[p] = 0;
        end

        // Reset held with both requesters asking; port 0 must be served first
        $display("[TB] reset with both valids high");
        startReq(0, 32'h0000_1000, 32'hA5A5_0000, 4'hF);
        startReq(1, 32'h0000_2000, 32'h5A5A_0000, 4'h0);
        repeat (5) applyStimulus();
        rstN     = 1'b1;
        randResp = 1'b1;
        waitIdle(100, "reset_drain");
        checkOutput("first_grant",  32'(grantLog.size() > 0 ? grantLog[0] : -1), 32'd0);
        checkOutput("second_grant", 32'(grantLog.size() > 1 ? grantLog[1] : -1), 32'd1);

        // s0 read with m_ready asserted early inside the blanking window
        $display("[TB] s0 read with early m_ready");
        randResp    = 1'b0;
        mReady      = 1'b0;
        pulseCnt[0] = 0;
        pulseCnt[1] = 0;
        applyStimulus();
        startReq(0, 32'h0000_1230, 32'h0, 4'h0);
        applyStimulus();
        checkOutput("t2_grant_mvalid", 32'(mValid), 32'd1);
        mReady = 1'b1;
        mRdata = 32'h1111_2222;
        applyStimulus();
        applyStimulus();
        checkOutput("t2_early_ignored", 32'(s0Ready), 32'd0);
        checkOutput("t2_still_valid", 32'(mValid), 32'd1);
        mReady = 1'b0;
        repeat (3) applyStimulus();
        mReady = 1'b1;
        mRdata = 32'hDEAD_BEEF;
        applyStimulus();
        checkOutput("t2_s0_ready", 32'(s0Ready), 32'd1);
        checkOutput("t2_s0_rdata", s0Rdata, 32'hDEAD_BEEF);
        mReady = 1'b0;
        repeat (2) applyStimulus();
        checkOutput("t2_pulse_count", 32'(pulseCnt[0]), 32'd1);

        // s1 write: master-side copies must match and hold until completion
        $display("[TB] s1 write");
        pulseCnt[0] = 0;
        pulseCnt[1] = 0;
        startReq(1, 32'h0000_0040, 32'h1234_5678, 4'h3);
        applyStimulus();
        checkOutput("t3_m_addr",  mAddr,  32'h0000_0040);
        checkOutput("t3_m_wdata", mWdata, 32'h1234_5678);
        checkOutput("t3_m_wstrb", 32'(mWstrb), 32'h3);
        repeat (6) applyStimulus();
        mReady = 1'b1;
        applyStimulus();
        checkOutput("t3_s1_ready", 32'(s1Ready), 32'd1);
        checkOutput("t3_m_addr_done", mAddr, 32'h0000_0040);
        mReady = 1'b0;
        repeat (2) applyStimulus();
        checkOutput("t3_s1_pulses", 32'(pulseCnt[1]), 32'd1);
        checkOutput("t3_s0_pulses", 32'(pulseCnt[0]), 32'd0);

        // Both ports requesting back-to-back for four grants
        $display("[TB] continuous requests from both ports");
        base       = grantLog.size();
        keepReq[0] = 1'b1;
        keepReq[1] = 1'b1;
        randResp   = 1'b1;
        newReq(0);
        newReq(1);
        n = 0;
        while (grantLog.size() < base + 4 && n < 200) begin
            applyStimulus();
            n++;
        end
        checkOutput("t4_four_grants", 32'(grantLog.size() >= base + 4), 32'd1);
        keepReq[0] = 1'b0;
        keepReq[1] = 1'b0;
        waitIdle(200, "t4_drain");
        for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            expPort = 0;
`else
            expPort = i % 2;
`endif
            gotPort = (base + i < grantLog.size()) ? grantLog[base + i] : -1;
            checkOutput($sformatf("t4_grant_%0d", i), 32'(gotPort), 32'(expPort));
        end

        // Reset pulled during the wait for m_ready aborts silently
        $display("[TB] reset during wait");
        randResp = 1'b0;
        mReady   = 1'b0;
        applyStimulus();
        newReq(1);
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!(mBusy && mAge >= BLANK + 1) && n < 20);
        checkOutput("t5_reached_wait", 32'(mBusy && mAge >= BLANK + 1), 32'd1);
        rstN   = 1'b0;
        mReady = 1'b1;
        applyStimulus();
        checkOutput("t5_rst_mvalid", 32'(mValid), 32'd0);
        checkOutput("t5_rst_s1_ready", 32'(s1Ready), 32'd0);
        rstN        = 1'b1;
        mReady      = 1'b0;
        pulseCnt[1] = 0;
        randResp    = 1'b1;
        waitIdle(100, "t5_drain");
        checkOutput("t5_new_s1_pulse", 32'(pulseCnt[1]), 32'd1);

        // s0 withdraws valid while the request is still in the blanking window
        $display("[TB] s0 drops valid during issue");
        randResp    = 1'b0;
        mReady      = 1'b0;
        applyStimulus();
        pulseCnt[0] = 0;
        newReq(0);
        applyStimulus();
        applyStimulus();
        reqValid[0] = 1'b0;
        randResp    = 1'b1;
        waitIdle(100, "t6_drain");
        applyStimulus();
        checkOutput("t6_s0_pulse", 32'(pulseCnt[0]), 32'd1);
        checkOutput("t6_idle_mvalid", 32'(mValid), 32'd0);

        // Randomized traffic with occasional resets
        $display("[TB] random traffic");
        randReq  = 1'b1;
        randResp = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) rstN = 1'b0;
            applyStimulus();
            rstN = 1'b1;
        end
        randReq = 1'b0;
        waitIdle(200, "random_drain");

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
